// File: rtl/approx_err_monitor.sv
// approx_err_monitor: streams N_VEC exact/approx output pairs, reports max abs error and threshold violations
// Ports: clk, rst_n (async active-low); start pulse begins a run; in_valid/in_ready sample handshake
// with exact/approx words; busy (RUN/DRAIN), done (results stable), max_err, viol_cnt, pass.
// Optional: define ERR_MON_SUM_EN to add sum_err, the running sum of abs errors over the run.
module approx_err_monitor #(
  parameter int OUT_W = 3,
  parameter int N_VEC = 16,
  parameter int ET = 1,
  localparam int CNT_W = $clog2(N_VEC + 1),
  localparam int SUM_W = OUT_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] exact,
  input  logic [OUT_W-1:0] approx,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] max_err,
  output logic [CNT_W-1:0] viol_cnt,
`ifdef ERR_MON_SUM_EN
  output logic [SUM_W-1:0] sum_err,
`endif
  output logic             pass
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [OUT_W-1:0] ET_W = OUT_W'(ET);
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, viol_q, viol_d;
  logic s1_v_q, s1_v_d;
  logic [OUT_W-1:0] s1_err_q, s1_err_d, max_q, max_d;
  logic acc, go;
`ifdef ERR_MON_SUM_EN
  logic [SUM_W-1:0] sum_q, sum_d;
  assign sum_err = sum_q;
`endif
  assign acc = (state_q == RUN) && in_valid;
  // start is only honoured from IDLE or DONE; it also clears stats and the pipeline
  assign go = start && (state_q == IDLE || state_q == DONE);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    max_d = max_q;
    viol_d = viol_q;
`ifdef ERR_MON_SUM_EN
    sum_d = sum_q;
`endif
    s1_v_d = acc;
    s1_err_d = (exact >= approx) ? exact - approx : approx - exact;
    if (acc) begin
      cnt_d = cnt_q + CNT_W'(1);
      state_d = (cnt_q == CNT_W'(N_VEC - 1)) ? DRAIN : RUN;
    end
    // once the last sample has left stage 1, stage 2 has applied it
    if (state_q == DRAIN && !s1_v_q) state_d = DONE;
    if (s1_v_q) begin
      max_d = (s1_err_q > max_q) ? s1_err_q : max_q;
      viol_d = viol_q + CNT_W'(s1_err_q > ET_W);
`ifdef ERR_MON_SUM_EN
      sum_d = sum_q + SUM_W'(s1_err_q);
`endif
    end
    if (go) begin
      state_d = RUN;
      cnt_d = '0;
      s1_v_d = 1'b0;
      max_d = '0;
      viol_d = '0;
`ifdef ERR_MON_SUM_EN
      sum_d = '0;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      s1_v_q <= 1'b0;
      s1_err_q <= '0;
      max_q <= '0;
      viol_q <= '0;
`ifdef ERR_MON_SUM_EN
      sum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      s1_v_q <= s1_v_d;
      s1_err_q <= s1_err_d;
      max_q <= max_d;
      viol_q <= viol_d;
`ifdef ERR_MON_SUM_EN
      sum_q <= sum_d;
`endif
    end
  end
  assign in_ready = state_q == RUN;
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign pass = done && viol_q == '0;
  assign max_err = max_q;
  assign viol_cnt = viol_q;
endmodule

// File: tb/tb_approx_err_monitor.sv
// tb_approx_err_monitor: scoreboard bench for approx_err_monitor
module tb_approx_err_monitor;
  localparam int OUT_W = 3;
  localparam int N_VEC = 16;
  localparam int ET = 1;
  localparam int CNT_W = $clog2(N_VEC + 1);
  localparam int SUM_W = OUT_W + CNT_W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [OUT_W-1:0] exact = '0;
  logic [OUT_W-1:0] approx = '0;
  logic in_ready, busy, done, pass;
  logic [OUT_W-1:0] max_err;
  logic [CNT_W-1:0] viol_cnt;
`ifdef ERR_MON_SUM_EN
  logic [SUM_W-1:0] sum_err;
`endif
  approx_err_monitor #(.OUT_W(OUT_W), .N_VEC(N_VEC), .ET(ET)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .exact(exact), .approx(approx), .busy(busy), .done(done), .max_err(max_err),
    .viol_cnt(viol_cnt),
`ifdef ERR_MON_SUM_EN
    .sum_err(sum_err),
`endif
    .pass(pass)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int due;
    int mx;
    int vc;
    int sm;
  } exp_t;
  exp_t sb[$];
  logic [OUT_W-1:0] ex_v[N_VEC];
  logic [OUT_W-1:0] ap_v[N_VEC];
  int checks = 0;
  int failures = 0;
  int r_lat, r_mx, r_vc, r_pass, r_sm;

  task automatic run(input bit toggle, input int start_at);
    int m_mx, m_vc, m_sm, n, t, e;
    bit last_acc;
    exp_t x;
    sb.delete();
    m_mx = 0; m_vc = 0; m_sm = 0; n = 0; t = 1; last_acc = 0;
    @(negedge clk) start = 1'b1; in_valid = 1'b0;
    @(negedge clk) start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || max_err !== '0 || viol_cnt !== '0) begin
      failures++;
      $display("FAIL run_entry busy=%b done=%b max=%0d viol=%0d want 1 0 0 0", busy, done, max_err, viol_cnt);
    end
    for (int k = 0; k < 200; k++) begin
      while (sb.size() > 0 && sb[0].due == cyc) begin
        x = sb.pop_front();
        checks++;
        if (max_err !== OUT_W'(x.mx) || viol_cnt !== CNT_W'(x.vc)) begin
          failures++;
          $display("FAIL stats max=%0d viol=%0d want %0d %0d", max_err, viol_cnt, x.mx, x.vc);
        end
`ifdef ERR_MON_SUM_EN
        checks++;
        if (sum_err !== SUM_W'(x.sm)) begin
          failures++;
          $display("FAIL sum_err got %0d want %0d", sum_err, x.sm);
        end
`endif
      end
      if (last_acc) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL ready_drop in_ready=%b want 0", in_ready);
        end
        last_acc = 0;
      end
      if (done === 1'b1) break;
      checks++;
      if (pass !== 1'b0) begin
        failures++;
        $display("FAIL pass_outside_done pass=%b want 0", pass);
      end
      in_valid = (n < N_VEC) && (!toggle || k % 2 == 0);
      exact = ex_v[n % N_VEC];
      approx = ap_v[n % N_VEC];
      start = (k == start_at);
      if (in_valid && in_ready === 1'b1) begin
        e = exact >= approx ? int'(exact) - int'(approx) : int'(approx) - int'(exact);
        if (e > m_mx) m_mx = e;
        if (e > ET) m_vc++;
        m_sm += e;
        n++;
        last_acc = (n == N_VEC);
        sb.push_back('{cyc + 2, m_mx, m_vc, m_sm});
      end
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_timeout done=%b want 1", done);
    end
    checks++;
    if (n != N_VEC || sb.size() != 0) begin
      failures++;
      $display("FAIL accepts got %0d pending %0d want %0d 0", n, sb.size(), N_VEC);
    end
    checks++;
    if (pass !== (m_vc == 0)) begin
      failures++;
      $display("FAIL pass_model got %b want %b", pass, m_vc == 0);
    end
    r_lat = t; r_mx = int'(max_err); r_vc = int'(viol_cnt); r_pass = int'(pass);
`ifdef ERR_MON_SUM_EN
    r_sm = int'(sum_err);
`else
    r_sm = m_sm;
`endif
  endtask

  task automatic check_final(input string nm, input int lat, input int mx, input int vc, input int ps, input int sm);
    checks++;
    if ((lat >= 0 && r_lat != lat) || r_mx != mx || r_vc != vc || r_pass != ps || r_sm != sm) begin
      failures++;
      $display("FAIL %s lat=%0d max=%0d viol=%0d pass=%0d sum=%0d want %0d %0d %0d %0d %0d",
               nm, r_lat, r_mx, r_vc, r_pass, r_sm, lat, mx, vc, ps, sm);
    end
  endtask

  task automatic set_single_err();
    for (int i = 0; i < N_VEC; i++) begin ex_v[i] = OUT_W'(i); ap_v[i] = OUT_W'(i); end
    ex_v[5] = 3'd6; ap_v[5] = 3'd3;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (in_ready !== 0 || busy !== 0 || done !== 0 || pass !== 0 || max_err !== 0 || viol_cnt !== 0) begin
      failures++;
      $display("FAIL reset_state rdy=%b busy=%b done=%b pass=%b max=%0d viol=%0d want all 0",
               in_ready, busy, done, pass, max_err, viol_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 0 || in_ready !== 0 || done !== 0) begin
      failures++;
      $display("FAIL idle_wait busy=%b rdy=%b done=%b want 0 0 0", busy, in_ready, done);
    end
  endtask

  task automatic test_exact_equal();
    for (int i = 0; i < N_VEC; i++) begin ex_v[i] = OUT_W'(i); ap_v[i] = OUT_W'(i); end
    run(0, -1);
    check_final("exact_equal", 19, 0, 0, 1, 0);
  endtask

  task automatic test_single_err();
    set_single_err();
    run(0, -1);
    check_final("single_err", 19, 3, 1, 0, 3);
  endtask

  task automatic test_err_at_et();
    for (int i = 0; i < N_VEC; i++) begin ex_v[i] = 3'd2; ap_v[i] = 3'd1; end
    run(0, -1);
    check_final("err_at_et", 19, 1, 0, 1, 16);
  endtask

  task automatic test_toggle();
    set_single_err();
    run(1, -1);
    check_final("toggle", -1, 3, 1, 0, 3);
  endtask

  task automatic test_start_in_run();
    set_single_err();
    run(0, 4);
    check_final("start_in_run", 19, 3, 1, 0, 3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N_VEC; i++) begin
      ex_v[i] = OUT_W'($urandom_range(0, 7));
      ap_v[i] = OUT_W'($urandom_range(0, 7));
    end
    run(0, -1);
    run(1, 3);
  endtask

  task automatic test_reset_mid();
    int acc;
    set_single_err();
    ex_v[0] = 3'd7; ap_v[0] = 3'd0;
    acc = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 50 && acc < 7; k++) begin
      in_valid = 1'b1;
      exact = ex_v[acc];
      approx = ap_v[acc];
      if (in_ready === 1'b1) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (max_err !== 3'd7 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset max=%0d busy=%b want 7 1", max_err, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 0 || busy !== 0 || done !== 0 || pass !== 0 || max_err !== 0 || viol_cnt !== 0) begin
      failures++;
      $display("FAIL async_reset rdy=%b busy=%b done=%b pass=%b max=%0d viol=%0d want all 0",
               in_ready, busy, done, pass, max_err, viol_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 0 || max_err !== 0) begin
      failures++;
      $display("FAIL post_reset_idle busy=%b max=%0d want 0 0", busy, max_err);
    end
    set_single_err();
    run(0, -1);
    check_final("fresh_after_reset", 19, 3, 1, 0, 3);
  endtask

  initial begin
    test_reset();
    test_exact_equal();
    test_single_err();
    test_err_at_et();
    test_toggle();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
